// File: rtl/conv_pkg.sv
// Shared types, size helpers and fixed-point helpers for the sequential
// convolution engine.
//   fixed_t       : default signed fixed-point pixel type
//   wide_t        : wide signed scratch type for rounding and saturation
//   SEL_*         : ld_sel encodings for the memory loader
//   out_dim()     : output extent of one spatial axis
//   idx_w()       : index width, never less than one bit
//   round_shift() : drop fractional bits, optionally round-half-up
//   sat_hit() / saturate() : detect and apply clamping to a signed width
package conv_pkg;

   localparam int FIXED_W = 16;
   typedef logic signed [FIXED_W-1:0] fixed_t;

   // Accumulators are sign-extended to this width before rounding and
   // clamping. The accumulator width must stay below it.
   localparam int WIDE_W = 64;
   typedef logic signed [WIDE_W-1:0] wide_t;

   localparam logic [1:0] SEL_X    = 2'd0;
   localparam logic [1:0] SEL_W    = 2'd1;
   localparam logic [1:0] SEL_B    = 2'd2;
   localparam logic [1:0] SEL_NONE = 2'd3;

   function automatic int out_dim(int in_sz, int filt, int pad, int stride, int dil);
      int eff;
      eff = filt + (filt - 1) * (dil - 1);
      return (in_sz - eff + 2 * pad) / stride + 1;
   endfunction

   function automatic int idx_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max_of(int a, int b);
      return (a > b) ? a : b;
   endfunction

   function automatic wide_t round_shift(wide_t v, int frac, logic rnd);
      wide_t half;
      half = (rnd && frac > 0) ? (wide_t'(1) <<< (frac - 1)) : '0;
      return (v + half) >>> frac;
   endfunction

   function automatic logic sat_hit(wide_t v, int dw);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (dw - 1));
      return (v > hi) || (v < lo);
   endfunction

   function automatic wide_t saturate(wide_t v, int dw);
      wide_t hi;
      wide_t lo;
      hi = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
      lo = -(wide_t'(1) <<< (dw - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Multiply-accumulate datapath for one output pixel.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : load the accumulator with bias_i scaled to the accumulator's
//                fixed-point position
//   tap_en_i   : a_i/b_i carry a valid tap this cycle (registered here)
//   a_i, b_i   : input pixel and filter weight
//   fin_i      : last product is being accumulated; capture the final result
//   round_i    : 0 = truncate, 1 = round-half-up
//   relu_i     : clamp negative results to zero
//   res_o      : registered output pixel
//   sat_o      : clamping occurred on the result captured by fin_i
//                (combinational, meaningful only while fin_i is high)
module conv_mac_unit
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int ACC_WIDTH  = 40
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] bias_i,
   input  logic                  tap_en_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic                  fin_i,
   input  logic                  round_i,
   input  logic                  relu_i,
   output logic [DATA_WIDTH-1:0] res_o,
   output logic                  sat_o
);

   localparam int PW = 2 * DATA_WIDTH;

   logic signed [DATA_WIDTH-1:0] a_q, b_q;
   logic signed [PW-1:0]         prod;
   logic signed [ACC_WIDTH-1:0]  prod_ext, acc_q, acc_d;
   wide_t                        acc_wide, shifted, clamped;
   logic [DATA_WIDTH-1:0]        res_d;

   // Operands outside a tap are forced to zero, so the accumulator can add
   // unconditionally every cycle it is not being loaded.
   assign prod     = PW'(a_q) * PW'(b_q);
   assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
   assign acc_d    = acc_q + prod_ext;

   // The result is taken from acc_d so the final product folds in during the
   // same cycle that captures the output.
   assign acc_wide = {{(WIDE_W-ACC_WIDTH){acc_d[ACC_WIDTH-1]}}, acc_d};
   assign shifted  = round_shift(acc_wide, FRAC_WIDTH, round_i);
   assign sat_o    = sat_hit(shifted, DATA_WIDTH);
   assign clamped  = saturate(shifted, DATA_WIDTH);

   always_comb begin
      res_d = clamped[DATA_WIDTH-1:0];
      if (relu_i && res_d[DATA_WIDTH-1]) res_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         res_o <= '0;
      end else begin
         a_q <= tap_en_i ? a_i : '0;
         b_q <= tap_en_i ? b_i : '0;
         if (load_i) acc_q <= {{(ACC_WIDTH-DATA_WIDTH){bias_i[DATA_WIDTH-1]}}, bias_i} << FRAC_WIDTH;
         else        acc_q <= acc_d;
         if (fin_i)  res_o <= res_d;
      end
   end

endmodule

// File: rtl/conv_seq_engine.sv
// Sequential 2-D convolution engine, one MAC per clock.
//   clk, rst            : clock, synchronous active-high reset
//   ld_en/ld_sel/ld_addr/ld_data : memory loader, honoured only in IDLE
//   cfg_relu, cfg_round : post-processing options, latched on start
//   start               : begin a full pass (IDLE only)
//   busy, done          : pass in progress / one-cycle end-of-pass pulse
//   out_valid/out_ready : result stream handshake
//   out_data/out_f/out_y/out_x : result pixel and its filter/row/column
//   sat_cnt             : saturated results in the current pass (sticky max)
//
// Handshake: out_valid rises with stable out_data and indices and stays high,
// with nothing changing, until a cycle where out_valid && out_ready; the
// transfer happens on that clock edge.
module conv_seq_engine
   import conv_pkg::*;
#(
   parameter  int D_IN       = 3,
   parameter  int H_IN       = 8,
   parameter  int W_IN       = 8,
   parameter  int N_FILTERS  = 4,
   parameter  int H_FILT     = 3,
   parameter  int W_FILT     = 3,
   parameter  int STRIDE     = 1,
   parameter  int PADDING    = 1,
   parameter  int DILATION   = 1,
   parameter  int DATA_WIDTH = 16,
   parameter  int FRAC_WIDTH = 8,
   parameter  int ACC_WIDTH  = 40,
   localparam int X_SZ  = D_IN * H_IN * W_IN,
   localparam int W_SZ  = N_FILTERS * D_IN * H_FILT * W_FILT,
   localparam int B_SZ  = N_FILTERS,
   localparam int AW    = idx_w(max_of(X_SZ, max_of(W_SZ, B_SZ))),
   localparam int H_OUT = out_dim(H_IN, H_FILT, PADDING, STRIDE, DILATION),
   localparam int W_OUT = out_dim(W_IN, W_FILT, PADDING, STRIDE, DILATION),
   localparam int F_W   = idx_w(N_FILTERS),
   localparam int Y_W   = idx_w(H_OUT),
   localparam int X_W   = idx_w(W_OUT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld_en,
   input  logic [1:0]            ld_sel,
   input  logic [AW-1:0]         ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic                  cfg_relu,
   input  logic                  cfg_round,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [F_W-1:0]        out_f,
   output logic [Y_W-1:0]        out_y,
   output logic [X_W-1:0]        out_x,
   output logic [15:0]           sat_cnt
);

   localparam int MEM_D = 1 << AW;
   localparam int C_W   = idx_w(D_IN);
   localparam int M_W   = idx_w(H_FILT);
   localparam int N_W   = idx_w(W_FILT);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_MAC, S_FLUSH, S_OUT, S_DONE} state_e;

   state_e           state_q;
   logic             busy_q, done_q, out_valid_q, relu_q, round_q;
   logic [F_W-1:0]   f_q;
   logic [Y_W-1:0]   y_q;
   logic [X_W-1:0]   x_q;
   logic [C_W-1:0]   c_q;
   logic [M_W-1:0]   m_q;
   logic [N_W-1:0]   n_q;
   logic [15:0]      sat_cnt_q;

   logic [DATA_WIDTH-1:0] x_mem [MEM_D];
   logic [DATA_WIDTH-1:0] w_mem [MEM_D];
   logic [DATA_WIDTH-1:0] b_mem [MEM_D];

   int                    iy, ix, xa, wa;
   logic                  in_bounds, last_tap, last_pix, mac_sat;
   logic [AW-1:0]         x_addr, w_addr, b_addr;
   logic [DATA_WIDTH-1:0] x_tap, w_tap, bias;

   // Loader writes only while idle; out-of-range addresses and SEL_NONE drop.
   always_ff @(posedge clk) begin
      if (!rst && state_q == S_IDLE && ld_en) begin
         case (ld_sel)
            SEL_X:   if (int'(ld_addr) < X_SZ) x_mem[ld_addr] <= ld_data;
            SEL_W:   if (int'(ld_addr) < W_SZ) w_mem[ld_addr] <= ld_data;
            SEL_B:   if (int'(ld_addr) < B_SZ) b_mem[ld_addr] <= ld_data;
            default: ;
         endcase
      end
   end

   // Tap address generation. Padding taps still spend their cycle but feed
   // a zero pixel, which keeps per-pixel latency fixed.
   always_comb begin
      iy        = int'(y_q) * STRIDE + int'(m_q) * DILATION - PADDING;
      ix        = int'(x_q) * STRIDE + int'(n_q) * DILATION - PADDING;
      in_bounds = (iy >= 0) && (iy < H_IN) && (ix >= 0) && (ix < W_IN);
      xa        = in_bounds ? (int'(c_q) * H_IN + iy) * W_IN + ix : 0;
      wa        = ((int'(f_q) * D_IN + int'(c_q)) * H_FILT + int'(m_q)) * W_FILT + int'(n_q);
   end

   assign x_addr = AW'(xa);
   assign w_addr = AW'(wa);
   assign b_addr = AW'(int'(f_q));
   assign x_tap  = in_bounds ? x_mem[x_addr] : '0;
   assign w_tap  = w_mem[w_addr];
   assign bias   = b_mem[b_addr];

   assign last_tap = (int'(c_q) == D_IN - 1) && (int'(m_q) == H_FILT - 1) && (int'(n_q) == W_FILT - 1);
   assign last_pix = (int'(x_q) == W_OUT - 1) && (int'(y_q) == H_OUT - 1) && (int'(f_q) == N_FILTERS - 1);

   conv_mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .load_i   (state_q == S_INIT),
      .bias_i   (bias),
      .tap_en_i (state_q == S_MAC),
      .a_i      (x_tap),
      .b_i      (w_tap),
      .fin_i    (state_q == S_FLUSH),
      .round_i  (round_q),
      .relu_i   (relu_q),
      .res_o    (out_data),
      .sat_o    (mac_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         relu_q      <= 1'b0;
         round_q     <= 1'b0;
         f_q         <= '0;
         y_q         <= '0;
         x_q         <= '0;
         c_q         <= '0;
         m_q         <= '0;
         n_q         <= '0;
         sat_cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  relu_q    <= cfg_relu;
                  round_q   <= cfg_round;
                  sat_cnt_q <= '0;
                  f_q       <= '0;
                  y_q       <= '0;
                  x_q       <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= S_INIT;
               end
            end
            S_INIT: begin
               c_q     <= '0;
               m_q     <= '0;
               n_q     <= '0;
               state_q <= S_MAC;
            end
            S_MAC: begin
               // n fastest, then m, then c.
               if (int'(n_q) == W_FILT - 1) begin
                  n_q <= '0;
                  if (int'(m_q) == H_FILT - 1) begin
                     m_q <= '0;
                     c_q <= (int'(c_q) == D_IN - 1) ? '0 : c_q + 1'b1;
                  end else begin
                     m_q <= m_q + 1'b1;
                  end
               end else begin
                  n_q <= n_q + 1'b1;
               end
               if (last_tap) state_q <= S_FLUSH;
            end
            S_FLUSH: begin
               out_valid_q <= 1'b1;
               if (mac_sat && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
               state_q <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  // x fastest, then y, then f.
                  if (int'(x_q) == W_OUT - 1) begin
                     x_q <= '0;
                     if (int'(y_q) == H_OUT - 1) begin
                        y_q <= '0;
                        f_q <= (int'(f_q) == N_FILTERS - 1) ? '0 : f_q + 1'b1;
                     end else begin
                        y_q <= y_q + 1'b1;
                     end
                  end else begin
                     x_q <= x_q + 1'b1;
                  end
                  if (last_pix) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_INIT;
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign out_f     = f_q;
   assign out_y     = y_q;
   assign out_x     = x_q;
   assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_conv_seq_engine.sv
module tb_conv_seq_engine;

   localparam int DW = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_en;
   logic [1:0]    ld_sel;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          cfg_relu, cfg_round, start;
   logic          busy, done, out_valid, out_ready;
   logic [DW-1:0] out_data;
   logic [0:0]    out_f;
   logic [1:0]    out_y, out_x;
   logic [15:0]   sat_cnt;

   int checks   = 0;
   int failures = 0;

   // In-bounds tap count per output pixel for a 3x3 map, 3x3 filter, pad 1.
   int tc [9];

   logic [DW-1:0] exp_q [$];

   // Observations of the latest pass.
   logic [DW-1:0] obs_data [16];
   logic [0:0]    obs_f [16];
   logic [1:0]    obs_y [16];
   logic [1:0]    obs_x [16];
   int            obs_cyc [16];
   int            n_out, done_cnt, extra_cnt, stall_changed;
   bit            timed_out, busy_after_start, busy_at_done;

   always #5 clk = ~clk;

   conv_seq_engine #(
      .D_IN(1), .H_IN(3), .W_IN(3), .N_FILTERS(1), .H_FILT(3), .W_FILT(3),
      .STRIDE(1), .PADDING(1), .DILATION(1), .DATA_WIDTH(16), .FRAC_WIDTH(8), .ACC_WIDTH(40)
   ) dut (
      .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
      .cfg_relu(cfg_relu), .cfg_round(cfg_round), .start(start), .busy(busy), .done(done),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_f(out_f), .out_y(out_y), .out_x(out_x), .sat_cnt(sat_cnt)
   );

   // ---------------- driver tasks ----------------
   task automatic load_word(input logic [1:0] sel, input int addr, input logic [DW-1:0] data);
      ld_en = 1'b1; ld_sel = sel; ld_addr = AW'(addr); ld_data = data;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   task automatic fill(input logic [1:0] sel, input logic [DW-1:0] data);
      for (int a = 0; a < 9; a++) load_word(sel, a, data);
   endtask

   // Runs one pass. stall_pix >= 0 holds out_ready low for 10 cycles on that
   // pixel; poke pulses start and loader writes during the stall. cfg inputs
   // are flipped right after start to show they are ignored mid-pass.
   task automatic run_pass(input int stall_pix, input bit poke, input bit relu_v, input bit round_v);
      int cyc;
      int stall_left;
      logic [DW-1:0] snap_d;
      logic [1:0] snap_y, snap_x;
      logic [0:0] snap_f;
      n_out = 0; done_cnt = 0; extra_cnt = 0; stall_changed = 0; busy_at_done = 1'b1;
      for (int i = 0; i < 16; i++) begin obs_data[i] = 'x; obs_cyc[i] = -1; end
      cfg_relu = relu_v; cfg_round = round_v; out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cfg_relu = ~relu_v; cfg_round = ~round_v;
      busy_after_start = busy;
      cyc = 0; stall_left = -1;
      snap_d = '0; snap_y = '0; snap_x = '0; snap_f = '0;
      while (done_cnt == 0 && cyc < 3000) begin
         ld_en = 1'b0; start = 1'b0;
         if (done) begin
            done_cnt++;
            busy_at_done = busy;
         end else if (out_valid) begin
            if (n_out == stall_pix && stall_left < 0) begin
               stall_left = 10;
               snap_d = out_data; snap_y = out_y; snap_x = out_x; snap_f = out_f;
            end
            if (stall_left > 0) begin
               if (out_data !== snap_d || out_y !== snap_y || out_x !== snap_x || out_f !== snap_f)
                  stall_changed++;
               out_ready = 1'b0;
               stall_left--;
               if (poke && stall_left == 5) begin
                  start = 1'b1; ld_en = 1'b1; ld_sel = 2'd0; ld_addr = 4'd4; ld_data = 16'h7777;
               end
               if (poke && stall_left == 4) begin
                  ld_en = 1'b1; ld_sel = 2'd1; ld_addr = 4'd4; ld_data = 16'h7777;
               end
            end else begin
               out_ready = 1'b1;
               if (n_out < 16) begin
                  obs_data[n_out] = out_data; obs_f[n_out] = out_f;
                  obs_y[n_out] = out_y; obs_x[n_out] = out_x; obs_cyc[n_out] = cyc;
               end
               n_out++;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      timed_out = (done_cnt == 0);
      ld_en = 1'b0; start = 1'b0; out_ready = 1'b1;
      repeat (6) begin
         if (out_valid || done) extra_cnt++;
         @(posedge clk); #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, out_valid, out_data, out_f, out_y, out_x, sat_cnt} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got busy=%b done=%b valid=%b data=%h f=%h y=%h x=%h sat=%h expected all zero",
                  busy, done, out_valid, out_data, out_f, out_y, out_x, sat_cnt);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic;
      fill(2'd0, 16'h0100);
      fill(2'd1, 16'h0100);
      load_word(2'd2, 0, 16'h0000);
      load_word(2'd3, 0, 16'h7777);
      run_pass(-1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) exp_q.push_back(16'(tc[i] * 256));
      checks++;
      if (timed_out !== 1'b0) begin failures++; $display("FAIL basic_timeout: got no done within budget, expected done"); end
      checks++;
      if (busy_after_start !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", busy_after_start); end
      checks++;
      if (n_out !== 9) begin failures++; $display("FAIL basic_count: got %0d expected 9", n_out); end
      checks++;
      if (obs_cyc[0] !== 11) begin failures++; $display("FAIL basic_latency: got %0d expected 11", obs_cyc[0]); end
      for (int i = 0; i < 9; i++) begin
         logic [DW-1:0] e;
         e = exp_q.pop_front();
         checks++;
         if (obs_data[i] !== e || obs_y[i] !== 2'(i / 3) || obs_x[i] !== 2'(i % 3) || obs_f[i] !== 1'b0) begin
            failures++;
            $display("FAIL basic_pix[%0d]: got data=%h f=%h y=%h x=%h expected data=%h f=0 y=%0d x=%0d",
                     i, obs_data[i], obs_f[i], obs_y[i], obs_x[i], e, i / 3, i % 3);
         end
         if (i > 0) begin
            checks++;
            if (obs_cyc[i] - obs_cyc[i-1] !== 12) begin
               failures++;
               $display("FAIL basic_spacing[%0d]: got %0d expected 12", i, obs_cyc[i] - obs_cyc[i-1]);
            end
         end
      end
      checks++;
      if (done_cnt !== 1 || busy_at_done !== 1'b0 || extra_cnt !== 0) begin
         failures++;
         $display("FAIL basic_done: got done=%0d busy_at_done=%b extra=%0d expected 1 0 0", done_cnt, busy_at_done, extra_cnt);
      end
      checks++;
      if (sat_cnt !== 16'd0) begin failures++; $display("FAIL basic_sat: got %0d expected 0", sat_cnt); end
   endtask

   task automatic test_backpressure;
      for (int pass = 0; pass < 2; pass++) begin
         run_pass(pass == 0 ? 3 : -1, pass == 0, 1'b0, 1'b0);
         checks++;
         if (timed_out !== 1'b0 || n_out !== 9 || done_cnt !== 1 || extra_cnt !== 0) begin
            failures++;
            $display("FAIL bp_count[%0d]: got timeout=%b outs=%0d done=%0d extra=%0d expected 0 9 1 0",
                     pass, timed_out, n_out, done_cnt, extra_cnt);
         end
         for (int i = 0; i < 9; i++) exp_q.push_back(16'(tc[i] * 256));
         for (int i = 0; i < 9; i++) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (obs_data[i] !== e || obs_y[i] !== 2'(i / 3) || obs_x[i] !== 2'(i % 3)) begin
               failures++;
               $display("FAIL bp_pix[%0d][%0d]: got data=%h y=%h x=%h expected data=%h y=%0d x=%0d",
                        pass, i, obs_data[i], obs_y[i], obs_x[i], e, i / 3, i % 3);
            end
         end
      end
      // stall_changed belongs to the first pass; re-derive from a fresh stalled pass.
      run_pass(3, 1'b0, 1'b0, 1'b0);
      checks++;
      if (stall_changed !== 0) begin failures++; $display("FAIL bp_stable: got %0d changed cycles expected 0", stall_changed); end
   endtask

   task automatic test_rounding;
      fill(2'd0, 16'h0001);
      fill(2'd1, 16'h0080);
      for (int r = 0; r < 2; r++) begin
         run_pass(-1, 1'b0, 1'b0, r[0]);
         for (int i = 0; i < 9; i++) exp_q.push_back(16'((tc[i] * 128 + r * 128) / 256));
         for (int i = 0; i < 9; i++) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (obs_data[i] !== e) begin
               failures++;
               $display("FAIL round%0d_pix[%0d]: got %h expected %h", r, i, obs_data[i], e);
            end
         end
      end
   endtask

   task automatic test_saturation;
      for (int s = 0; s < 2; s++) begin
         fill(2'd0, s == 0 ? 16'h7F00 : 16'h8100);
         fill(2'd1, 16'h0100);
         run_pass(-1, 1'b0, 1'b0, 1'b0);
         for (int i = 0; i < 9; i++) exp_q.push_back(s == 0 ? 16'h7FFF : 16'h8000);
         for (int i = 0; i < 9; i++) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (obs_data[i] !== e) begin
               failures++;
               $display("FAIL sat%0d_pix[%0d]: got %h expected %h", s, i, obs_data[i], e);
            end
         end
         checks++;
         if (sat_cnt !== 16'd9) begin failures++; $display("FAIL sat%0d_count: got %0d expected 9", s, sat_cnt); end
      end
   endtask

   task automatic test_mid_reset;
      int stray;
      out_ready = 1'b1; cfg_relu = 1'b0; cfg_round = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (16) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || out_x !== 2'd1 || out_data !== 16'h8000 || sat_cnt !== 16'd1) begin
         failures++;
         $display("FAIL rst_pre: got busy=%b x=%h data=%h sat=%0d expected 1 1 8000 1", busy, out_x, out_data, sat_cnt);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({busy, done, out_valid, out_data, out_f, out_y, out_x, sat_cnt} !== '0) begin
         failures++;
         $display("FAIL rst_mid_outputs: got busy=%b done=%b valid=%b data=%h f=%h y=%h x=%h sat=%h expected all zero",
                  busy, done, out_valid, out_data, out_f, out_y, out_x, sat_cnt);
      end
      stray = 0;
      repeat (20) begin
         if (out_valid || done || busy) stray++;
         @(posedge clk); #1;
      end
      checks++;
      if (stray !== 0) begin failures++; $display("FAIL rst_idle: got %0d active cycles expected 0", stray); end
      run_pass(-1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (timed_out !== 1'b0 || n_out !== 9 || sat_cnt !== 16'd9) begin
         failures++;
         $display("FAIL rst_rerun: got timeout=%b outs=%0d sat=%0d expected 0 9 9", timed_out, n_out, sat_cnt);
      end
      for (int i = 0; i < 9; i++) exp_q.push_back(16'h8000);
      for (int i = 0; i < 9; i++) begin
         logic [DW-1:0] e;
         e = exp_q.pop_front();
         checks++;
         if (obs_data[i] !== e) begin failures++; $display("FAIL rst_pix[%0d]: got %h expected %h", i, obs_data[i], e); end
      end
   endtask

   task automatic test_bias_relu;
      fill(2'd0, 16'h0100);
      fill(2'd1, 16'h0100);
      load_word(2'd2, 0, 16'hF000);
      for (int r = 0; r < 2; r++) begin
         run_pass(-1, 1'b0, r[0], 1'b0);
         for (int i = 0; i < 9; i++) exp_q.push_back(r == 1 ? 16'h0000 : 16'(tc[i] * 256 - 16 * 256));
         for (int i = 0; i < 9; i++) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            checks++;
            if (obs_data[i] !== e) begin
               failures++;
               $display("FAIL relu%0d_pix[%0d]: got %h expected %h", r, i, obs_data[i], e);
            end
         end
         checks++;
         if (sat_cnt !== 16'd0) begin failures++; $display("FAIL relu%0d_sat: got %0d expected 0", r, sat_cnt); end
      end
   endtask

   initial begin
      tc = '{4, 6, 4, 6, 9, 6, 4, 6, 4};
      rst = 1'b1; ld_en = 1'b0; ld_sel = '0; ld_addr = '0; ld_data = '0;
      cfg_relu = 1'b0; cfg_round = 1'b0; start = 1'b0; out_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_rounding();
      test_saturation();
      test_mid_reset();
      test_bias_relu();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_seq_engine.md
Name: conv_seq_engine

Overview:
Sequential, parametrised 2-D convolution engine: one multiply-accumulate (MAC) per clock over input maps, filters and biases held in internal memories, with stride, padding and dilation.
- Output pixels leave on a ready/valid stream.
- Full-precision accumulation, selectable rounding, saturation and optional ReLU.
- Sits between the feature-map loader and the next layer; replaces whole-map-per-cycle compute with a bounded-latency datapath.

Parameters:
D_IN, 3, input channels
H_IN, 8, input height
W_IN, 8, input width
N_FILTERS, 4, filter count
H_FILT, 3, filter height
W_FILT, 3, filter width
STRIDE, 1, spatial stride
PADDING, 1, zero padding on each side
DILATION, 1, tap spacing
DATA_WIDTH, 16, signed fixed-point width
FRAC_WIDTH, 8, fractional bits
ACC_WIDTH, 40, accumulator width; must be at least 2*DATA_WIDTH + clog2(D_IN*H_FILT*W_FILT) + 1
AW, derived, clog2 of the largest of the X, W and B memory sizes

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ld_en  in  1  memory write strobe; accepted only in IDLE
ld_sel  in  2  target memory: 0=X, 1=W, 2=B, 3=ignored
ld_addr  in  AW  flat address; X: (c*H_IN+y)*W_IN+x; W: ((f*D_IN+c)*H_FILT+m)*W_FILT+n; B: f
ld_data  in  DATA_WIDTH  write data
cfg_relu  in  1  clamp negative results to 0; sampled at start
cfg_round  in  1  0=truncate, 1=round-half-up; sampled at start
start  in  1  begin a full pass; accepted only in IDLE
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of pass
out_valid  out  1  result valid
out_ready  in  1  consumer ready
out_data  out  DATA_WIDTH  result pixel
out_f  out  clog2(N_FILTERS)  filter index of result
out_y  out  clog2(H_OUT)  row index of result
out_x  out  clog2(W_OUT)  column index of result
sat_cnt  out  16  count of saturated results in the current pass

Behaviour:
- Derived sizes:
  - H_EFF = H_FILT + (H_FILT-1)*(DILATION-1); W_EFF likewise.
  - H_OUT = (H_IN - H_EFF + 2*PADDING)/STRIDE + 1; W_OUT likewise.
  - K = D_IN*H_FILT*W_FILT.
- Reset:
  - FSM goes to IDLE; busy, done, out_valid, out_data, out_f, out_y, out_x and sat_cnt go to 0.
  - Memory contents are not reset.
  - Reset mid-pass aborts the pass with no done pulse.
- FSM states: IDLE -> INIT -> MAC -> FLUSH -> OUT -> (INIT | DONE) -> IDLE.
  - IDLE: apply ld_en writes; ignore out-of-range addresses and ld_sel=3. An accepted start latches cfg bits, clears sat_cnt and zeroes the f/y/x indices.
  - INIT (1 cycle): acc = sign-extended Bias[f] << FRAC_WIDTH.
  - MAC (K cycles): issue one tap per cycle, iterating c, then m, then n, with n fastest.
    - Operand read is registered; accumulation lags the read by one cycle.
    - Tap coordinates: in_y = y*STRIDE + m*DILATION - PADDING; in_x likewise.
    - Out-of-bounds taps still take their cycle and contribute exactly 0, so latency is fixed.
  - FLUSH (1 cycle): the last product is accumulated.
  - Then compute the result:
    - r = (acc + (cfg_round ? 1<<(FRAC_WIDTH-1) : 0)) >>> FRAC_WIDTH.
    - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; increment sat_cnt (sticky at 0xFFFF) when clamping occurs.
    - Apply ReLU after saturation.
  - OUT: out_valid=1 with data and indices held stable until out_valid && out_ready.
    - On handshake, advance x, then y, then f (x fastest).
    - Go to INIT, or to DONE after the last pixel.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
- Throughput: K+3 cycles per pixel when out_ready is held high.
- Ignored inputs:
  - start while busy is ignored.
  - ld_en while busy is ignored; memories are frozen for the whole pass.
  - cfg changes mid-pass have no effect.
- Products are full 2*DATA_WIDTH; no intermediate truncation.

Decomposition:
- Package conv_pkg holds:
  - fixed_t;
  - the functions for H_OUT/W_OUT derivation, saturate() and round_shift();
  - the ld_sel encoding constants.
- One sub-module, conv_mac_unit: registered multiply, accumulator with clear/load-bias, and round/saturate/ReLU output stage.
- Address generation and FSM stay in the top level.

Test Plan:
- Common config for all scenarios: D_IN=1, H_IN=W_IN=3, N_FILTERS=1, 3x3 filter, PADDING=1.
- All X=0x0100, all W=0x0100, B=0, out_ready=1 -> 9 outputs in order f/y/x; corners 0x0400, edges 0x0600, centre 0x0900; outputs 12 cycles apart; done pulses once.
- All X=0x0001, all W=0x0080 -> centre 0x0004 with cfg_round=0, 0x0005 with cfg_round=1, proving full-precision accumulation.
- All X=0x7F00, all W=0x0100 -> centre 0x7FFF and sat_cnt=9; repeat with X=0x8100 -> 0x8000.
- All-ones input, B=0xF000, cfg_relu=0 -> corner 0xF400; cfg_relu=1 -> corner 0x0000.
- out_ready low 10 cycles on pixel 3; start and ld_en pulsed while busy -> out_data and indices stable, no extra results, memories unchanged.
- rst asserted mid-MAC -> next cycle all outputs 0 and IDLE; a new start gives correct full results with no reload of memories.
